alu_share_arb: RTL and testbench

// - Shares the single 32-bit ALU between two requesters (0: execute stage, 1: address/branch unit).
// - Round-robin arbitration with valid/ready handshakes on the request and response sides.
// - Registers the operands, drives the ALU inputs, captures C/Z/O and returns them to the granted requester.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_share_arb_rr_arb2.sv | 34 +++
 rtl/alu_share_arb.sv | 156 +++++++++++++++
 tb/tb_alu_share_arb.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing arbiter: opcode constants,
// FSM state encoding and default widths.
package alu_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int MODW_DEF  = 3;

    // ALU Mod opcode encoding
    localparam logic [MODW_DEF-1:0] ALU_AND = 3'b000;
    localparam logic [MODW_DEF-1:0] ALU_OR  = 3'b001;
    localparam logic [MODW_DEF-1:0] ALU_SLT = 3'b011;
    localparam logic [MODW_DEF-1:0] ALU_ADD = 3'b100;
    localparam logic [MODW_DEF-1:0] ALU_SUB = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_share_arb_rr_arb2.sv
// Two-way round-robin grant. Purely combinational: a lone requester always
// wins, and on a tie the requester that did not win last time is chosen.
module rr_arb2 (
    input  logic [1:0] req_valid,
    input  logic       last_grant,
    output logic [1:0] grant,
    output logic       grant_idx
);

    // Pick the winner from the current requests and the previous owner
    always_comb begin
        grant     = 2'b00;
        grant_idx = 1'b0;
        case (req_valid)
            2'b01: begin
                grant     = 2'b01;
                grant_idx = 1'b0;
            end
            2'b10: begin
                grant     = 2'b10;
                grant_idx = 1'b1;
            end
            2'b11: begin
                grant_idx = ~last_grant;
                grant     = last_grant ? 2'b01 : 2'b10;
            end
            default: begin
                grant     = 2'b00;
                grant_idx = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one combinational ALU between two requesters (0: execute stage,
// 1: address/branch unit). One operation in flight at a time:
// IDLE (accept) -> EXEC (ALU evaluates) -> RESP (hold result until taken).
// Optional feature macro: ALU_ARB_STICKY_OVF_EN adds per-requester sticky
// overflow flags (ovf_sticky) with a clear input (ovf_clr).
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int MODW  = MODW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    input  logic [MODW-1:0]  req_mod0,
    input  logic [MODW-1:0]  req_mod1,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_c,
    output logic             rsp_z,
    output logic             rsp_o,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [MODW-1:0]  alu_mod,
    input  logic [WIDTH-1:0] alu_c,
    input  logic             alu_z,
    input  logic             alu_o
`ifdef ALU_ARB_STICKY_OVF_EN
    ,
    output logic [1:0]       ovf_sticky,
    input  logic [1:0]       ovf_clr
`endif
);

    state_t           state, state_nxt;
    logic             owner;
    logic             last_grant;
    logic             accept;
    logic [1:0]       grant;
    logic             grant_idx;

    logic [WIDTH-1:0] op_a_p0;
    logic [WIDTH-1:0] op_b_p0;
    logic [MODW-1:0]  op_mod_p0;
    logic [WIDTH-1:0] rsp_c_p1;
    logic             rsp_z_p1;
    logic             rsp_o_p1;

    rr_arb2 u_arb (
        .req_valid  (req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    // Next-state and handshake outputs; reset masks both handshake directions
    always_comb begin
        state_nxt = state;
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rst) begin
                    req_ready = grant;
                    if ((req_valid & grant) != 2'b00) begin
                        accept    = 1'b1;
                        state_nxt = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (!rst) begin
                    rsp_valid = owner ? 2'b10 : 2'b01;
                end
                if (rsp_ready[owner]) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Control state: FSM, owner of the in-flight op, round-robin history
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state <= state_nxt;
            if (accept) begin
                owner      <= grant_idx;
                last_grant <= grant_idx;
            end
        end
    end

    // Operand latch at acceptance (p0) and result capture at the end of EXEC (p1)
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a_p0   <= '0;
            op_b_p0   <= '0;
            op_mod_p0 <= MODW'(ALU_ADD);
            rsp_c_p1  <= '0;
            rsp_z_p1  <= 1'b0;
            rsp_o_p1  <= 1'b0;
        end else begin
            if (accept) begin
                op_a_p0   <= grant_idx ? req_a1   : req_a0;
                op_b_p0   <= grant_idx ? req_b1   : req_b0;
                op_mod_p0 <= grant_idx ? req_mod1 : req_mod0;
            end
            if (state == ST_EXEC) begin
                rsp_c_p1 <= alu_c;
                rsp_z_p1 <= alu_z;
                rsp_o_p1 <= alu_o;
            end
        end
    end

    // Operand registers only change on acceptance, so the ALU inputs hold
    // their last values in every state other than EXEC.
    assign alu_a   = op_a_p0;
    assign alu_b   = op_b_p0;
    assign alu_mod = op_mod_p0;
    assign rsp_c   = rsp_c_p1;
    assign rsp_z   = rsp_z_p1;
    assign rsp_o   = rsp_o_p1;

`ifdef ALU_ARB_STICKY_OVF_EN
    logic [1:0] ovf_set;

    assign ovf_set = ((state == ST_EXEC) && alu_o) ? (owner ? 2'b10 : 2'b01) : 2'b00;

    // Sticky overflow per requester; a set in the same cycle beats a clear
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_sticky <= 2'b00;
        end else begin
            ovf_sticky <= (ovf_sticky & ~ovf_clr) | ovf_set;
        end
    end
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: behavioural ALU attached to the ALU ports,
// directed spec scenarios followed by randomized transactions, all checked
// against a transaction-level reference model.
module tb_alu_share_arb;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_a0, req_b0, req_a1, req_b1;
    logic [2:0]  req_mod0, req_mod1;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_c;
    logic        rsp_z, rsp_o;
    logic [31:0] alu_a, alu_b;
    logic [2:0]  alu_mod;
    logic [31:0] alu_c;
    logic        alu_z, alu_o;
    logic [1:0]  ovf_sticky_obs;
    logic [1:0]  ovf_clr;

    int   checks = 0;
    int   errors = 0;
    logic exp_lastg;
    logic [1:0] exp_sticky;

    always #5 clk = ~clk;

    alu_share_arb #(.WIDTH(32), .MODW(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a0     (req_a0),
        .req_b0     (req_b0),
        .req_a1     (req_a1),
        .req_b1     (req_b1),
        .req_mod0   (req_mod0),
        .req_mod1   (req_mod1),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_c      (rsp_c),
        .rsp_z      (rsp_z),
        .rsp_o      (rsp_o),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_mod    (alu_mod),
        .alu_c      (alu_c),
        .alu_z      (alu_z),
        .alu_o      (alu_o)
`ifdef ALU_ARB_STICKY_OVF_EN
        ,
        .ovf_sticky (ovf_sticky_obs),
        .ovf_clr    (ovf_clr)
`endif
    );

`ifndef ALU_ARB_STICKY_OVF_EN
    assign ovf_sticky_obs = 2'b00;
`endif

    // Combinational ALU: O is carry-out for ADD and borrow for SUB
    always_comb begin
        logic [32:0] wide;
        wide  = 33'd0;
        alu_c = 32'd0;
        alu_o = 1'b0;
        case (alu_mod)
            3'b000: alu_c = alu_a & alu_b;
            3'b001: alu_c = alu_a | alu_b;
            3'b011: alu_c = {31'd0, ($signed(alu_a) < $signed(alu_b))};
            3'b100: begin
                wide  = {1'b0, alu_a} + {1'b0, alu_b};
                alu_c = wide[31:0];
                alu_o = wide[32];
            end
            3'b110: begin
                alu_c = alu_a - alu_b;
                alu_o = (alu_a < alu_b);
            end
            default: alu_c = 32'd0;
        endcase
        alu_z = (alu_c == 32'd0);
    end

    // Reference result of one operation: {o, z, c}
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] m);
        logic [31:0] c;
        logic        o;
        c = 32'd0;
        o = 1'b0;
        if (m == ALU_AND)      c = a & b;
        else if (m == ALU_OR)  c = a | b;
        else if (m == ALU_SLT) c = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
        else if (m == ALU_ADD) begin
            c = a + b;
            o = (64'(a) + 64'(b)) > 64'h0000_0000_FFFF_FFFF;
        end else if (m == ALU_SUB) begin
            c = a - b;
            o = (64'(a) < 64'(b));
        end
        return {o, (c == 32'd0), c};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = 2'b11;
        rsp_ready = 2'b00;
        ovf_clr   = 2'b00;
        #1;
        chk("req_ready_in_reset", 32'(req_ready), 32'd0);
        chk("rsp_valid_in_reset", 32'(rsp_valid), 32'd0);
        tick();
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_c", rsp_c, 32'd0);
        chk("rst_rsp_z", 32'(rsp_z), 32'd0);
        chk("rst_rsp_o", 32'(rsp_o), 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_alu_mod", 32'(alu_mod), 32'd4);
        chk("rst_sticky", 32'(ovf_sticky_obs), 32'd0);
        rst        = 1'b0;
        req_valid  = 2'b00;
        exp_lastg  = 1'b1;
        exp_sticky = 2'b00;
        #1;
    endtask

    // One full transaction: arbitration, EXEC drive, response, optional backpressure
    task automatic run_txn(input logic [1:0] v,
                           input logic [31:0] a0, input logic [31:0] b0, input logic [2:0] m0,
                           input logic [31:0] a1, input logic [31:0] b1, input logic [2:0] m1,
                           input int hold, input logic clr_exec);
        logic        w;
        logic [31:0] ea, eb;
        logic [2:0]  em;
        logic [33:0] r;
        logic [1:0]  onehot;
        w      = (v == 2'b11) ? ~exp_lastg : v[1];
        onehot = w ? 2'b10 : 2'b01;
        ea     = w ? a1 : a0;
        eb     = w ? b1 : b0;
        em     = w ? m1 : m0;
        r      = model(ea, eb, em);
        req_valid = v;
        req_a0 = a0; req_b0 = b0; req_mod0 = m0;
        req_a1 = a1; req_b1 = b1; req_mod1 = m1;
        rsp_ready = 2'b00;
        #1;
        chk("req_ready_idle", 32'(req_ready), 32'(onehot));
        tick();
        exp_lastg = w;
        // EXEC: no acceptance even with both requesting
        req_valid = 2'b11;
        req_a0 = ~a0; req_a1 = ~a1;
        ovf_clr = clr_exec ? onehot : 2'b00;
        #1;
        chk("req_ready_exec", 32'(req_ready), 32'd0);
        chk("rsp_valid_exec", 32'(rsp_valid), 32'd0);
        chk("alu_a_exec", alu_a, ea);
        chk("alu_b_exec", alu_b, eb);
        chk("alu_mod_exec", 32'(alu_mod), 32'(em));
        tick();
        ovf_clr = 2'b00;
        if (r[33]) exp_sticky[w] = 1'b1;
        else if (clr_exec) exp_sticky[w] = 1'b0;
        #1;
        chk("rsp_valid_resp", 32'(rsp_valid), 32'(onehot));
        chk("rsp_c_resp", rsp_c, r[31:0]);
        chk("rsp_z_resp", 32'(rsp_z), 32'(r[32]));
        chk("rsp_o_resp", 32'(rsp_o), 32'(r[33]));
        chk("req_ready_resp", 32'(req_ready), 32'd0);
`ifdef ALU_ARB_STICKY_OVF_EN
        chk("sticky_resp", 32'(ovf_sticky_obs), 32'(exp_sticky));
`endif
        // Backpressure: only the non-owner is ready, which must be ignored
        for (int i = 0; i < hold; i++) begin
            rsp_ready = ~onehot;
            tick();
            chk("rsp_valid_hold", 32'(rsp_valid), 32'(onehot));
            chk("rsp_c_hold", rsp_c, r[31:0]);
            chk("req_ready_hold", 32'(req_ready), 32'd0);
        end
        rsp_ready = onehot;
        req_valid = 2'b00;
        tick();
        chk("rsp_valid_after", 32'(rsp_valid), 32'd0);
        rsp_ready = 2'b00;
        #1;
    endtask

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0]  ops [5];
        logic [31:0] ra0, rb0, ra1, rb1;
        ops[0] = ALU_AND; ops[1] = ALU_OR; ops[2] = ALU_SLT; ops[3] = ALU_ADD; ops[4] = ALU_SUB;
        rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00; ovf_clr = 2'b00;
        req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
        req_mod0 = ALU_ADD; req_mod1 = ALU_ADD;
        exp_lastg = 1'b1; exp_sticky = 2'b00;
        tick();
        do_reset();

        // Single op 5+3
        run_txn(2'b01, 32'd5, 32'd3, ALU_ADD, 32'd0, 32'd0, ALU_ADD, 0, 1'b0);
        chk("single_c", rsp_c, 32'd8);
        chk("single_z", 32'(rsp_z), 32'd0);
        chk("single_o", 32'(rsp_o), 32'd0);

        // Contention from reset
        do_reset();
        run_txn(2'b11, 32'd10, 32'd4, ALU_ADD, 32'd7, 32'd7, ALU_SUB, 0, 1'b0);
        chk("tie1_c_req0", rsp_c, 32'd14);
        run_txn(2'b11, 32'd10, 32'd4, ALU_ADD, 32'd7, 32'd7, ALU_SUB, 0, 1'b0);
        chk("tie2_c_req1", rsp_c, 32'd0);
        chk("tie2_z_req1", 32'(rsp_z), 32'd1);
        run_txn(2'b11, 32'd10, 32'd4, ALU_ADD, 32'd7, 32'd7, ALU_SUB, 0, 1'b0);
        chk("tie3_c_req0", rsp_c, 32'd14);

        // Backpressure for 5 cycles
        run_txn(2'b01, 32'h0000_00F0, 32'h0000_000F, ALU_OR, 32'd0, 32'd0, ALU_ADD, 5, 1'b0);
        chk("bp_c", rsp_c, 32'h0000_00FF);

        // Signed SLT and carry overflow
        run_txn(2'b01, 32'hFFFF_FFFF, 32'd1, ALU_SLT, 32'd0, 32'd0, ALU_ADD, 0, 1'b0);
        chk("slt_c", rsp_c, 32'd1);
        run_txn(2'b01, 32'hFFFF_FFFF, 32'd1, ALU_ADD, 32'd0, 32'd0, ALU_ADD, 0, 1'b0);
        chk("ovf_c", rsp_c, 32'd0);
        chk("ovf_z", 32'(rsp_z), 32'd1);
        chk("ovf_o", 32'(rsp_o), 32'd1);

        // Nothing requested: no ready
        req_valid = 2'b00;
        #1;
        chk("idle_none_ready", 32'(req_ready), 32'd0);

        // Reset while in EXEC
        req_valid = 2'b01; req_a0 = 32'd100; req_b0 = 32'd1; req_mod0 = ALU_ADD;
        tick();
        req_valid = 2'b00;
        rst = 1'b1;
        #1;
        chk("rst_exec_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_exec_req_ready", 32'(req_ready), 32'd0);
        tick();
        chk("rst_exec_rsp_c", rsp_c, 32'd0);
        chk("rst_exec_alu_a", alu_a, 32'd0);
        chk("rst_exec_alu_mod", 32'(alu_mod), 32'd4);
        chk("rst_exec_rsp_valid2", 32'(rsp_valid), 32'd0);
        rst = 1'b0; exp_lastg = 1'b1; exp_sticky = 2'b00;
        #1;
        chk("rst_exec_idle_valid", 32'(rsp_valid), 32'd0);
        run_txn(2'b10, 32'd0, 32'd0, ALU_ADD, 32'd9, 32'd2, ALU_SUB, 0, 1'b0);
        chk("post_rst_req1_c", rsp_c, 32'd7);

`ifdef ALU_ARB_STICKY_OVF_EN
        run_txn(2'b10, 32'd0, 32'd0, ALU_ADD, 32'hFFFF_FFFF, 32'd1, ALU_ADD, 0, 1'b0);
        chk("sticky_set", 32'(ovf_sticky_obs), 32'd2);
        ovf_clr = 2'b10;
        tick();
        ovf_clr = 2'b00;
        exp_sticky = 2'b00;
        chk("sticky_clr", 32'(ovf_sticky_obs), 32'd0);
        run_txn(2'b10, 32'd0, 32'd0, ALU_ADD, 32'hFFFF_FFFF, 32'd1, ALU_ADD, 0, 1'b1);
        chk("sticky_set_wins", 32'(ovf_sticky_obs), 32'd2);
`endif

        // Randomized transactions
        for (int n = 0; n < 40; n++) begin
            ra0 = $urandom; rb0 = ($urandom_range(0, 3) == 0) ? ra0 : $urandom;
            ra1 = $urandom; rb1 = ($urandom_range(0, 3) == 0) ? ra1 : $urandom;
            run_txn(2'($urandom_range(1, 3)), ra0, rb0, ops[$urandom_range(0, 4)],
                    ra1, rb1, ops[$urandom_range(0, 4)], int'($urandom_range(0, 3)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
